half_inning_sequencer: RTL and testbench

Game-flow controller that sits in front of the out-count LED block. It turns debounced umpire button pulses into a ball/strike count and one-cycle `out_pulse` requests, then stalls play after the third out. It waits for the out-count block's `change_pulse` and advances the inning/half (top/bottom) register, finishing with a game-over state after the final half-inning.

---
 rtl/baseball_pkg.sv | 18 +
 rtl/count_thermo.sv | 25 ++
 rtl/half_inning_sequencer.sv | 174 +++++++++++++++++
 tb/tb_half_inning_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/baseball_pkg.sv
// Shared game-flow types and count limits for the half-inning sequencer.
package baseball_pkg;

    typedef enum logic [1:0] {
        HIS_PLAY        = 2'd0,
        HIS_WAIT_CHANGE = 2'd1,
        HIS_DONE        = 2'd2
    } his_state_t;

    localparam logic [1:0] MAX_BALLS     = 2'd3;
    localparam logic [1:0] MAX_STRIKES   = 2'd2;
    localparam logic [1:0] OUTS_PER_HALF = 2'd3;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/count_thermo.sv
// Registered saturating count-to-thermometer LED encoder (0 -> all off, >=WIDTH -> all on).
module count_thermo #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       count,
    output logic [WIDTH-1:0] led
);

    logic [WIDTH-1:0] thermo;

    always_comb begin
        thermo = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (32'(count) > i) thermo[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) led <= '0;
        else       led <= thermo;
    end

endmodule

// File: rtl/half_inning_sequencer.sv
// Ball/strike/out game-flow FSM and inning register in front of the out-count LED block.
// Optional WAIT_CHANGE watchdog enabled by defining HIS_WATCHDOG_EN.
//
// state           | meaning
// HIS_PLAY        | accepting umpire buttons, one event per cycle
// HIS_WAIT_CHANGE | third out issued, waiting for change_pulse
// HIS_DONE        | final half complete, game_over held until reset
module half_inning_sequencer
    import baseball_pkg::*;
#(
    parameter int INNINGS     = 9,
    parameter int WDOG_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       strike_in,
    input  logic       ball_in,
    input  logic       foul_in,
    input  logic       out_in,
    input  logic       change_pulse,
    output logic       out_pulse,
    output logic       walk_pulse,
    output logic [2:0] ball_led,
    output logic [1:0] strike_led,
    output logic [3:0] inning,
    output logic       bottom_half,
    output logic       game_over
`ifdef HIS_WATCHDOG_EN
    ,
    output logic       wdog_err
`endif
);

    if (INNINGS < 1 || INNINGS > 15 || WDOG_CYCLES < 1) begin : g_bad_param
        $error("half_inning_sequencer: INNINGS must be 1..15 and WDOG_CYCLES >= 1");
    end

    localparam logic [3:0] LAST_INNING = 4'(INNINGS);

    his_state_t state, state_next;
    logic [1:0] balls, balls_next;
    logic [1:0] strikes, strikes_next;
    logic [1:0] outs, outs_next;
    logic [3:0] inning_next;
    logic       bottom_next;
    logic       out_next, walk_next;
    logic       do_out, advance;
    logic       wdog_fire;

`ifdef HIS_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_cnt;

    // Down-counter loaded on entry; terminal count with no change_pulse forces the advance.
    assign wdog_fire = (state == HIS_WAIT_CHANGE) && !change_pulse && (wdog_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else begin
            if (state_next == HIS_WAIT_CHANGE && state != HIS_WAIT_CHANGE)
                wdog_cnt <= WDOG_W'(WDOG_CYCLES - 1);
            else if (state == HIS_WAIT_CHANGE && wdog_cnt != '0)
                wdog_cnt <= wdog_cnt - 1'b1;
            if (wdog_fire) wdog_err <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        balls_next   = balls;
        strikes_next = strikes;
        outs_next    = outs;
        inning_next  = inning;
        bottom_next  = bottom_half;
        out_next     = 1'b0;
        walk_next    = 1'b0;
        do_out       = 1'b0;
        advance      = 1'b0;

        case (state)
            HIS_PLAY: begin
                if (out_in || (strike_in && strikes == MAX_STRIKES)) begin
                    do_out = 1'b1;
                end else if (strike_in) begin
                    strikes_next = strikes + 2'd1;
                end else if (foul_in) begin
                    if (strikes < MAX_STRIKES) strikes_next = strikes + 2'd1;
                end else if (ball_in) begin
                    if (balls < MAX_BALLS) begin
                        balls_next = balls + 2'd1;
                    end else begin
                        walk_next    = 1'b1;
                        balls_next   = 2'd0;
                        strikes_next = 2'd0;
                    end
                end
            end
            HIS_WAIT_CHANGE: begin
                if (change_pulse || wdog_fire) advance = 1'b1;
            end
            HIS_DONE: begin
            end
            default: state_next = HIS_PLAY;
        endcase

        if (do_out) begin
            out_next     = 1'b1;
            balls_next   = 2'd0;
            strikes_next = 2'd0;
            outs_next    = sat_inc2(outs);
            if (outs_next == OUTS_PER_HALF) state_next = HIS_WAIT_CHANGE;
        end

        if (advance) begin
            outs_next    = 2'd0;
            balls_next   = 2'd0;
            strikes_next = 2'd0;
            state_next   = HIS_PLAY;
            if (!bottom_half) begin
                bottom_next = 1'b1;
            end else if (inning == LAST_INNING) begin
                // Final half: scoreboard freezes on the bottom of the last inning.
                state_next = HIS_DONE;
            end else begin
                bottom_next = 1'b0;
                inning_next = inning + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HIS_PLAY;
            balls       <= 2'd0;
            strikes     <= 2'd0;
            outs        <= 2'd0;
            inning      <= 4'd1;
            bottom_half <= 1'b0;
            out_pulse   <= 1'b0;
            walk_pulse  <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_next;
            balls       <= balls_next;
            strikes     <= strikes_next;
            outs        <= outs_next;
            inning      <= inning_next;
            bottom_half <= bottom_next;
            out_pulse   <= out_next;
            walk_pulse  <= walk_next;
            game_over   <= (state_next == HIS_DONE);
        end
    end

    count_thermo #(.WIDTH(3)) u_ball_thermo (
        .clk   (clk),
        .reset (reset),
        .count (balls_next),
        .led   (ball_led)
    );

    count_thermo #(.WIDTH(2)) u_strike_thermo (
        .clk   (clk),
        .reset (reset),
        .count (strikes_next),
        .led   (strike_led)
    );

endmodule

// File: tb/tb_half_inning_sequencer.sv
// Self-checking bench: directed vector table, corner sequences, and random play against a count-level model.
module tb_half_inning_sequencer;

    localparam int INNINGS = 9;
    localparam int WDOG    = 16;

    logic clk = 1'b0;
    logic reset, strike_in, ball_in, foul_in, out_in, change_pulse;
    logic out_pulse, walk_pulse, bottom_half, game_over;
    logic [2:0] ball_led;
    logic [1:0] strike_led;
    logic [3:0] inning;
`ifdef HIS_WATCHDOG_EN
    logic wdog_err;
`endif

    always #5 clk = ~clk;

    half_inning_sequencer #(.INNINGS(INNINGS), .WDOG_CYCLES(WDOG)) dut (
        .clk          (clk),
        .reset        (reset),
        .strike_in    (strike_in),
        .ball_in      (ball_in),
        .foul_in      (foul_in),
        .out_in       (out_in),
        .change_pulse (change_pulse),
        .out_pulse    (out_pulse),
        .walk_pulse   (walk_pulse),
        .ball_led     (ball_led),
        .strike_led   (strike_led),
        .inning       (inning),
        .bottom_half  (bottom_half),
        .game_over    (game_over)
`ifdef HIS_WATCHDOG_EN
        ,
        .wdog_err     (wdog_err)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Count-level game model: half index 0..2*INNINGS-1 maps to inning/half.
    int m_balls, m_strikes, m_outs, m_half, m_wait_cnt;
    bit m_waiting, m_over, m_out, m_walk, m_err;

    function void model_reset();
        m_balls = 0; m_strikes = 0; m_outs = 0; m_half = 0; m_wait_cnt = 0;
        m_waiting = 0; m_over = 0; m_out = 0; m_walk = 0; m_err = 0;
    endfunction

    function void model_advance();
        m_outs = 0; m_balls = 0; m_strikes = 0; m_waiting = 0;
        if (m_half == 2*INNINGS - 1) m_over = 1;
        else m_half++;
    endfunction

    function void model_step(bit s, bit b, bit f, bit o, bit c);
        m_out = 0; m_walk = 0;
        if (m_over) return;
        if (m_waiting) begin
            if (c) model_advance();
            else begin
                m_wait_cnt++;
`ifdef HIS_WATCHDOG_EN
                if (m_wait_cnt == WDOG) begin
                    m_err = 1;
                    model_advance();
                end
`endif
            end
            return;
        end
        if (o || (s && m_strikes == 2)) begin
            m_out = 1; m_balls = 0; m_strikes = 0; m_outs++;
            if (m_outs == 3) begin
                m_waiting = 1; m_wait_cnt = 0;
            end
        end else if (s) begin
            m_strikes++;
        end else if (f) begin
            if (m_strikes < 2) m_strikes++;
        end else if (b) begin
            if (m_balls == 3) begin
                m_walk = 1; m_balls = 0; m_strikes = 0;
            end else m_balls++;
        end
    endfunction

    function logic [7:0] therm(int n);
        return 8'((1 << n) - 1);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("out_pulse",   8'(out_pulse),   8'(m_out));
        chk("walk_pulse",  8'(walk_pulse),  8'(m_walk));
        chk("ball_led",    8'(ball_led),    therm(m_balls));
        chk("strike_led",  8'(strike_led),  therm(m_strikes));
        chk("inning",      8'(inning),      8'(m_half / 2 + 1));
        chk("bottom_half", 8'(bottom_half), 8'(m_half % 2));
        chk("game_over",   8'(game_over),   8'(m_over));
`ifdef HIS_WATCHDOG_EN
        chk("wdog_err",    8'(wdog_err),    8'(m_err));
`endif
    endtask

    task automatic cycle(input bit s, input bit b, input bit f, input bit o, input bit c);
        strike_in = s; ball_in = b; foul_in = f; out_in = o; change_pulse = c;
        @(posedge clk);
        #1;
        model_step(s, b, f, o, c);
        check_model();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        strike_in = 0; ball_in = 0; foul_in = 0; out_in = 0; change_pulse = 0;
        reset = 1'b1;
        #1;
        model_reset();
        check_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        bit s, b, f, o, c;
        bit e_out, e_walk;
        logic [2:0] e_ball;
        logic [1:0] e_strike;
    } vec_t;

    function automatic vec_t v(bit s, bit b, bit f, bit o, bit c, bit eo, bit ew,
                               logic [2:0] eb, logic [1:0] es);
        vec_t r;
        r.s = s; r.b = b; r.f = f; r.o = o; r.c = c;
        r.e_out = eo; r.e_walk = ew; r.e_ball = eb; r.e_strike = es;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        // strikeout via fouls at two strikes, walk clearing strikes, priority, stray change_pulse
        tbl.push_back(v(1,0,0,0,0, 0,0, 3'b000, 2'b01));
        tbl.push_back(v(1,0,0,0,0, 0,0, 3'b000, 2'b11));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0,0,1,0,0, 0,0, 3'b000, 2'b11));
        tbl.push_back(v(1,0,0,0,0, 1,0, 3'b000, 2'b00));
        tbl.push_back(v(0,0,0,0,0, 0,0, 3'b000, 2'b00));
        tbl.push_back(v(0,1,0,0,0, 0,0, 3'b001, 2'b00));
        tbl.push_back(v(1,0,0,0,0, 0,0, 3'b001, 2'b01));
        tbl.push_back(v(0,1,0,0,0, 0,0, 3'b011, 2'b01));
        tbl.push_back(v(0,1,0,0,0, 0,0, 3'b111, 2'b01));
        tbl.push_back(v(0,1,0,0,0, 0,1, 3'b000, 2'b00));
        tbl.push_back(v(0,0,0,0,0, 0,0, 3'b000, 2'b00));
        tbl.push_back(v(0,1,0,1,0, 1,0, 3'b000, 2'b00));
        tbl.push_back(v(0,1,0,0,0, 0,0, 3'b001, 2'b00));
        tbl.push_back(v(0,0,0,0,1, 0,0, 3'b001, 2'b00));
        tbl.push_back(v(1,1,1,0,0, 0,0, 3'b001, 2'b01));

        reset = 1'b0;
        strike_in = 0; ball_in = 0; foul_in = 0; out_in = 0; change_pulse = 0;
        #2;
        do_reset();
        chk("reset_inning", 8'(inning), 8'd1);

        foreach (tbl[i]) begin
            cycle(tbl[i].s, tbl[i].b, tbl[i].f, tbl[i].o, tbl[i].c);
            chk("tbl_out",    8'(out_pulse),  8'(tbl[i].e_out));
            chk("tbl_walk",   8'(walk_pulse), 8'(tbl[i].e_walk));
            chk("tbl_ball",   8'(ball_led),   8'(tbl[i].e_ball));
            chk("tbl_strike", 8'(strike_led), 8'(tbl[i].e_strike));
        end

        // Third out (outs already 2), inputs ignored while waiting, then change.
        cycle(0, 1, 0, 1, 0);
        chk("third_out_pulse", 8'(out_pulse), 8'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 1, 0);
            chk("wait_no_pulse", 8'(out_pulse), 8'd0);
            chk("wait_no_count", 8'({ball_led, strike_led}), 8'd0);
        end
        cycle(0, 0, 0, 0, 1);
        chk("change_bottom", 8'(bottom_half), 8'd1);
        chk("change_inning", 8'(inning), 8'd1);

        // Play through to the end of the game.
        for (int h = 0; h < 2*INNINGS && !m_over; h++) begin
            for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
            idle();
            idle();
            cycle(0, 0, 0, 0, 1);
        end
        chk("game_over_set",   8'(game_over), 8'd1);
        chk("game_over_inning", 8'(inning), 8'(INNINGS));
        cycle(0, 0, 0, 1, 0);
        chk("done_no_out", 8'(out_pulse), 8'd0);
        cycle(0, 0, 0, 0, 1);
        chk("done_still_over", 8'(game_over), 8'd1);

        // Reset while waiting for change, with out_pulse still high.
        do_reset();
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
        idle();
        cycle(0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
        chk("pre_reset_out", 8'(out_pulse), 8'd1);
        do_reset();
        chk("rst_inning", 8'(inning), 8'd1);
        chk("rst_bottom", 8'(bottom_half), 8'd0);
        chk("rst_leds",   8'({ball_led, strike_led}), 8'd0);
        idle();
        chk("rst_no_replay", 8'(out_pulse), 8'd0);
        cycle(0, 1, 0, 0, 0);
        chk("rst_play_resumed", 8'(ball_led), 8'b001);

`ifdef HIS_WATCHDOG_EN
        do_reset();
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 0);
        for (int k = 0; k < WDOG - 1; k++) idle();
        chk("wdog_not_yet", 8'(bottom_half), 8'd0);
        chk("wdog_err_clear", 8'(wdog_err), 8'd0);
        idle();
        chk("wdog_bottom", 8'(bottom_half), 8'd1);
        chk("wdog_err_set", 8'(wdog_err), 8'd1);
        for (int k = 0; k < 4; k++) cycle(0, 1, 0, 0, 0);
        chk("wdog_err_sticky", 8'(wdog_err), 8'd1);
`endif

        // Random play against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(499) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(4) == 0, $urandom_range(3) == 0, $urandom_range(5) == 0,
                      $urandom_range(5) == 0, $urandom_range(2) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
